stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Memory-stage sequencer downstream of the instruction decoder; executes the stack-group instructions PUSH, POP, RCALL and RET.
- Owns the stack pointer (SP) and drives the data-memory port for stack accesses.
- Splits the 10-bit PC save/restore of RCALL/RET into two 8-bit memory cycles.
- Returns the popped byte or the restored PC to the register file / PC logic.

Parameters:
- DATA_WIDTH, 8, data-memory word width
- PC_WIDTH, 10, program counter width
- SP_WIDTH, 8, stack pointer / data-memory address width
- SP_RESET, 8'hBF, SP value after reset (top of ATtiny20 SRAM)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue strobe from control; sampled only when busy=0
- op_push  in  1  PUSH selected
- op_pop  in  1  POP selected
- op_rcall  in  1  RCALL selected
- op_ret  in  1  RET selected
- push_data  in  DATA_WIDTH  register value Rr for PUSH
- pc_ret  in  PC_WIDTH  return address (PC+1) for RCALL
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_re
- mem_addr  out  SP_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- sp  out  SP_WIDTH  current stack pointer
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse in the last cycle of a sequence
- pop_valid  out  1  one-cycle pulse; pop_data is valid
- pop_data  out  DATA_WIDTH  byte popped by POP
- pc_load  out  1  one-cycle pulse; pc_target is valid
- pc_target  out  PC_WIDTH  PC restored by RET
- op_err  out  1  one-cycle pulse; start with op_* not one-hot

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sp=SP_RESET.
  - busy, done, mem_we, mem_re, pop_valid, pc_load and op_err all 0.
  - mem_addr, mem_wdata, pop_data and pc_target all 0.
  - Reset mid-sequence aborts the sequence; no further memory strobes.
- Issue:
  - start in cycle T with busy=0 and exactly one op_* set: latch op, push_data and pc_ret; busy=1 from T+1.
  - start while busy=1 is ignored.
  - start with zero or multiple op_* set: op_err=1 at T+1, state stays IDLE.
- States: IDLE, PUSH_WR, POP_RD, POP_CAP, CALL_WR_LO, CALL_WR_HI, RET_RD_HI, RET_RD_LO, RET_CAP.
- mem_we, mem_re and mem_addr are combinational from state and sp.
- Sequences (relative to issue cycle T; SP before issue = S):
  - PUSH, 1 cycle:
    - T+1 PUSH_WR: mem_we=1, addr=S, wdata=push_data; sp<=S-1; done=1.
  - POP, 2 cycles:
    - T+1 POP_RD: mem_re=1, addr=S+1; sp<=S+1.
    - T+2 POP_CAP: pop_data=mem_rdata, pop_valid=1, done=1.
  - RCALL, 2 cycles:
    - T+1 CALL_WR_LO: we=1, addr=S, wdata=pc_ret[7:0]; sp<=S-1.
    - T+2 CALL_WR_HI: we=1, addr=S-1, wdata={6'b0,pc_ret[9:8]}; sp<=S-2; done=1.
  - RET, 3 cycles:
    - T+1 RET_RD_HI: re=1, addr=S+1; sp<=S+1.
    - T+2 RET_RD_LO: capture hi=mem_rdata[1:0]; re=1, addr=S+2; sp<=S+2.
    - T+3 RET_CAP: pc_target={hi,mem_rdata}, pc_load=1, done=1.
- Next issue:
  - After done, state returns to IDLE; busy=0 in the cycle after done.
  - Earliest next start is sampled in that cycle, so there are no back-to-back issues.
- mem_we and mem_re are never high in the same cycle.
- Strobes default to 0 in every state not listed above.
- SP arithmetic is modulo 2^SP_WIDTH:
  - 8'h00 decremented wraps to 8'hFF; 8'hFF incremented wraps to 8'h00.
  - No saturation and no error flag for wrap.
- pop_data and pc_target hold their last value between pulses.

Test Plan:
- Reset then PUSH with push_data=8'h5A -> at T+1 mem_we=1, addr=8'hBF, wdata=8'h5A, done=1; then sp=8'hBE.
- POP after that PUSH, memory returning 8'h5A -> at T+1 re=1, addr=8'hBF; at T+2 pop_valid=1, pop_data=8'h5A; sp=8'hBF.
- RCALL pc_ret=10'h2C7 then RET -> writes 8'hC7@BF and 8'h02@BE; RET reads BE then BF; pc_load=1 with pc_target=10'h2C7 at T+3; final sp=8'hBF.
- start asserted during an RCALL sequence, and start with op_push=op_pop=1 -> the busy-time start is ignored (no extra strobes); the illegal issue gives op_err=1 for 1 cycle, no memory access, sp unchanged.
- rst_n pulsed low during RET_RD_LO -> immediately busy=0, mem_re=0, sp=8'hBF; no pc_load afterwards.
- SP wrap: 192 PUSHes from reset -> sp=8'hFF after the push to 8'h00; the following POP reads addr 8'h00.

Source files
------------

// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Memory-stage sequencer for the stack instructions PUSH, POP, RCALL and RET.
//   Owns the stack pointer and drives the data-memory port for stack accesses.
//   RCALL/RET move the PC in two memory words: the low word at the higher
//   address, the high bits one below it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op_*       issue strobe and one-hot operation select (sampled when idle)
//   push_data         byte to push (PUSH)
//   pc_ret            return address to save (RCALL)
//   mem_rdata         memory read data, valid the cycle after mem_re
//   mem_addr/wdata    memory address / write data
//   mem_we/mem_re     write / read strobes (never both high)
//   sp                current stack pointer
//   busy, done        sequence in progress / last cycle of a sequence
//   pop_valid/data    popped byte (POP)
//   pc_load/target    restored PC (RET)
//   op_err            start issued with op_* not one-hot
module stack_sequencer #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          PC_WIDTH   = 10,
  parameter int unsigned          SP_WIDTH   = 8,
  parameter logic [SP_WIDTH-1:0]  SP_RESET   = 8'hBF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_push,
  input  logic                  op_pop,
  input  logic                  op_rcall,
  input  logic                  op_ret,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [PC_WIDTH-1:0]   pc_ret,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [SP_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  busy,
  output logic                  done,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic                  op_err
);

  localparam int unsigned HI_W = PC_WIDTH - DATA_WIDTH;
  localparam logic [SP_WIDTH-1:0] SP_ONE = {{(SP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE,
    PUSH_WR,
    POP_RD,
    POP_CAP,
    CALL_WR_LO,
    CALL_WR_HI,
    RET_RD_HI,
    RET_RD_LO,
    RET_CAP
  } state_e;

  state_e                state_q;
  logic [SP_WIDTH-1:0]   sp_q;
  logic [DATA_WIDTH-1:0] push_data_q;
  logic [PC_WIDTH-1:0]   pc_ret_q;
  logic [HI_W-1:0]       hi_q;
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic [PC_WIDTH-1:0]   pc_target_q;
  logic                  op_err_q;

  logic [SP_WIDTH-1:0]   sp_inc_d;
  logic [SP_WIDTH-1:0]   sp_dec_d;
  logic [3:0]            op_vec;
  logic                  op_onehot;

  // SP arithmetic wraps modulo 2^SP_WIDTH by construction.
  assign sp_inc_d  = sp_q + SP_ONE;
  assign sp_dec_d  = sp_q - SP_ONE;
  assign op_vec    = {op_push, op_pop, op_rcall, op_ret};
  assign op_onehot = $onehot(op_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      push_data_q <= '0;
      pc_ret_q    <= '0;
      hi_q        <= '0;
      pop_data_q  <= '0;
      pc_target_q <= '0;
      op_err_q    <= 1'b0;
    end else begin
      op_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op_onehot) begin
              push_data_q <= push_data;
              pc_ret_q    <= pc_ret;
              if (op_push)       state_q <= PUSH_WR;
              else if (op_pop)   state_q <= POP_RD;
              else if (op_rcall) state_q <= CALL_WR_LO;
              else               state_q <= RET_RD_HI;
            end else begin
              op_err_q <= 1'b1;
            end
          end
        end
        PUSH_WR: begin
          sp_q    <= sp_dec_d;
          state_q <= IDLE;
        end
        POP_RD: begin
          sp_q    <= sp_inc_d;
          state_q <= POP_CAP;
        end
        POP_CAP: begin
          pop_data_q <= mem_rdata;
          state_q    <= IDLE;
        end
        CALL_WR_LO: begin
          sp_q    <= sp_dec_d;
          state_q <= CALL_WR_HI;
        end
        CALL_WR_HI: begin
          sp_q    <= sp_dec_d;
          state_q <= IDLE;
        end
        RET_RD_HI: begin
          sp_q    <= sp_inc_d;
          state_q <= RET_RD_LO;
        end
        RET_RD_LO: begin
          // Data from the RET_RD_HI read is on mem_rdata now.
          hi_q    <= mem_rdata[HI_W-1:0];
          sp_q    <= sp_inc_d;
          state_q <= RET_CAP;
        end
        RET_CAP: begin
          pc_target_q <= {hi_q, mem_rdata};
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; capture states forward mem_rdata
  // in the pulse cycle and the held copy afterwards.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    pop_valid = 1'b0;
    pc_load   = 1'b0;
    pop_data  = pop_data_q;
    pc_target = pc_target_q;
    case (state_q)
      PUSH_WR: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = push_data_q;
        done      = 1'b1;
      end
      POP_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_inc_d;
      end
      POP_CAP: begin
        pop_valid = 1'b1;
        pop_data  = mem_rdata;
        done      = 1'b1;
      end
      CALL_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_ret_q[DATA_WIDTH-1:0];
      end
      CALL_WR_HI: begin
        mem_we               = 1'b1;
        mem_addr             = sp_q;
        mem_wdata[HI_W-1:0]  = pc_ret_q[PC_WIDTH-1:DATA_WIDTH];
        done                 = 1'b1;
      end
      RET_RD_HI, RET_RD_LO: begin
        mem_re   = 1'b1;
        mem_addr = sp_inc_d;
      end
      RET_CAP: begin
        pc_load   = 1'b1;
        pc_target = {hi_q, mem_rdata};
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign sp     = sp_q;
  assign busy   = (state_q != IDLE);
  assign op_err = op_err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       op_push = 1'b0, op_pop = 1'b0, op_rcall = 1'b0, op_ret = 1'b0;
  logic [7:0] push_data = '0;
  logic [9:0] pc_ret = '0;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr, mem_wdata, sp, pop_data;
  logic       mem_we, mem_re, busy, done, pop_valid, pc_load, op_err;
  logic [9:0] pc_target;

  int n_vec = 0;
  int n_err = 0;

  stack_sequencer #(
    .DATA_WIDTH(8),
    .PC_WIDTH  (10),
    .SP_WIDTH  (8),
    .SP_RESET  (8'hBF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_push  (op_push),
    .op_pop   (op_pop),
    .op_rcall (op_rcall),
    .op_ret   (op_ret),
    .push_data(push_data),
    .pc_ret   (pc_ret),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .sp       (sp),
    .busy     (busy),
    .done     (done),
    .pop_valid(pop_valid),
    .pop_data (pop_data),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: strobes sampled mid-cycle, acted on at the edge.
  logic [7:0] mem [256];
  logic       we_s = 1'b0, re_s = 1'b0;
  logic [7:0] addr_s = '0, wdata_s = '0;

  always @(negedge clk) begin
    we_s    = mem_we;
    re_s    = mem_re;
    addr_s  = mem_addr;
    wdata_s = mem_wdata;
  end

  always @(posedge clk) begin
    if (re_s) mem_rdata <= mem[addr_s];
    if (we_s) mem[addr_s] <= wdata_s;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [7:0] pd, input logic [9:0] pc);
    start     = st;
    op_push   = op[3];
    op_pop    = op[2];
    op_rcall  = op[1];
    op_ret    = op[0];
    push_data = pd;
    pc_ret    = pc;
  endtask

  typedef struct {
    logic       start;
    logic [3:0] op;      // {push, pop, rcall, ret}
    logic [7:0] pd;
    logic [9:0] pc;
    logic       busy, done, we, re;
    logic [7:0] addr, wd, sp;
    logic       pv;
    logic [7:0] popd;
    logic       pl;
    logic [9:0] pt;
    logic       err;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // inputs before edge i | outputs checked just after edge i
    tbl[0]  = '{1'b1, 4'b1000, 8'h5A, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'hBF, 8'h5A, 8'hBF, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBE, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 8'h00, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBF, 8'h00, 8'hBE, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b1, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[5]  = '{1'b1, 4'b0010, 8'h00, 10'h2C7, 1'b1, 1'b0, 1'b1, 1'b0, 8'hBF, 8'hC7, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[6]  = '{1'b1, 4'b1000, 8'hEE, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'hBE, 8'h02, 8'hBE, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBD, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[8]  = '{1'b1, 4'b0001, 8'h00, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBE, 8'h00, 8'hBD, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[9]  = '{1'b1, 4'b1000, 8'h33, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBF, 8'h00, 8'hBE, 1'b0, 8'h5A, 1'b0, 10'h000, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b1, 10'h2C7, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b0};
    tbl[12] = '{1'b1, 4'b1100, 8'h77, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b0};
    tbl[14] = '{1'b1, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b0};
    tbl[16] = '{1'b1, 4'b0011, 8'h00, 10'h155, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b1};
    tbl[17] = '{1'b0, 4'b0000, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hBF, 1'b0, 8'h5A, 1'b0, 10'h2C7, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);       chk("rst done", done, 0);
    chk("rst we", mem_we, 0);       chk("rst re", mem_re, 0);
    chk("rst addr", mem_addr, 0);   chk("rst wdata", mem_wdata, 0);
    chk("rst sp", sp, 8'hBF);       chk("rst pop_valid", pop_valid, 0);
    chk("rst pop_data", pop_data, 0); chk("rst pc_load", pc_load, 0);
    chk("rst pc_target", pc_target, 0); chk("rst op_err", op_err, 0);
    @(negedge clk) rst_n = 1'b1;

    // Table: PUSH, POP, RCALL/RET with busy-time starts, illegal issues
    for (int i = 0; i < 18; i++) begin
      @(negedge clk) drive(tbl[i].start, tbl[i].op, tbl[i].pd, tbl[i].pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), done, tbl[i].done);
      chk($sformatf("v%0d we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d re", i), mem_re, tbl[i].re);
      chk($sformatf("v%0d addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d sp", i), sp, tbl[i].sp);
      chk($sformatf("v%0d pop_valid", i), pop_valid, tbl[i].pv);
      chk($sformatf("v%0d pop_data", i), pop_data, tbl[i].popd);
      chk($sformatf("v%0d pc_load", i), pc_load, tbl[i].pl);
      chk($sformatf("v%0d pc_target", i), pc_target, tbl[i].pt);
      chk($sformatf("v%0d op_err", i), op_err, tbl[i].err);
    end

    // Reset asserted during RET_RD_LO aborts the return
    @(negedge clk) drive(1'b1, 4'b0010, 8'h00, 10'h155);
    @(negedge clk) drive(1'b0, 4'b0000, 8'h00, 10'h000);
    @(negedge clk);
    @(negedge clk) drive(1'b1, 4'b0001, 8'h00, 10'h000);
    @(negedge clk) drive(1'b0, 4'b0000, 8'h00, 10'h000);
    @(posedge clk);
    #1;
    chk("abort pre re", mem_re, 1);
    chk("abort pre sp", sp, 8'hBE);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort re", mem_re, 0);
    chk("abort sp", sp, 8'hBF);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort c%0d pc_load", i), pc_load, 0);
      chk($sformatf("abort c%0d re", i), mem_re, 0);
    end

    // SP wrap: 192 pushes from SP_RESET, last one writes 8'h00
    for (int i = 0; i < 192; i++) begin
      @(negedge clk) drive(1'b1, 4'b1000, 8'(i) ^ 8'hA5, 10'h000);
      @(posedge clk);
      #1;
      if (i == 191) begin
        chk("wrap last we", mem_we, 1);
        chk("wrap last addr", mem_addr, 8'h00);
        chk("wrap last wdata", mem_wdata, 8'h1A);
      end
      @(negedge clk) drive(1'b0, 4'b0000, 8'h00, 10'h000);
      @(posedge clk);
    end
    #1;
    chk("wrap sp", sp, 8'hFF);
    @(negedge clk) drive(1'b1, 4'b0100, 8'h00, 10'h000);
    @(posedge clk);
    #1;
    chk("wrap pop re", mem_re, 1);
    chk("wrap pop addr", mem_addr, 8'h00);
    @(negedge clk) drive(1'b0, 4'b0000, 8'h00, 10'h000);
    @(posedge clk);
    #1;
    chk("wrap pop valid", pop_valid, 1);
    chk("wrap pop data", pop_data, 8'h1A);
    chk("wrap pop sp", sp, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
